// File: rtl/beam_weight_cmul.sv
// beam_weight_cmul: per-channel complex beamforming weight stage.
// Multiplies each aligned I/Q sample by a double-buffered complex weight.
// The result is rounded half-up, shifted right by FRAC and saturated to DW bits.
// Sample-to-output latency is 4 clocks: a sample strobed at edge N is presented at edge N+4.
// Optional build macro CONJ_WEIGHT_EN: multiply by conj(w) instead of w.
module beam_weight_cmul #(
  parameter int DW   = 18,
  parameter int WW   = 18,
  parameter int FRAC = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] dinI,
  input  logic signed [DW-1:0] dinQ,
  input  logic                 w_load,
  input  logic signed [WW-1:0] wI,
  input  logic signed [WW-1:0] wQ,
  input  logic                 w_commit,
  output logic                 w_pending,
  output logic                 dout_valid,
  output logic signed [DW-1:0] doutI,
  output logic signed [DW-1:0] doutQ,
  output logic                 sat_flag
);

  localparam int PW = DW + WW;
  localparam int SW = PW + 1;
  localparam logic signed [WW-1:0] W_UNITY  = WW'((2 ** FRAC) - 1);
  localparam logic signed [SW-1:0] RND_HALF = SW'(2 ** (FRAC - 1));
  localparam logic signed [DW-1:0] OUT_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OUT_MIN  = {1'b1, {(DW-1){1'b0}}};

  logic signed [WW-1:0] shadow_i, shadow_q, active_i, active_q;

  logic                 s1_valid, s2_valid, s3_valid, s4_valid;
  logic signed [DW-1:0] s1_di, s1_dq;
  logic signed [WW-1:0] s1_wi, s1_wq;
  logic signed [PW-1:0] p_ii, p_qq, p_iq, p_qi;
  logic signed [SW-1:0] sum_i, sum_q;
  logic signed [SW-1:0] rnd_i, rnd_q;

  logic                 clip_i, clip_q;
  logic signed [DW-1:0] sat_i, sat_q;

  // Double-buffered weight: a simultaneous load+commit promotes the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_i  <= W_UNITY;
      shadow_q  <= '0;
      active_i  <= W_UNITY;
      active_q  <= '0;
      w_pending <= 1'b0;
    end else begin
      if (w_load) begin
        shadow_i  <= wI;
        shadow_q  <= wQ;
        w_pending <= 1'b1;
      end else if (w_commit) begin
        w_pending <= 1'b0;
      end
      if (w_commit) begin
        active_i <= shadow_i;
        active_q <= shadow_q;
      end
    end
  end

  // S1..S4: capture sample with its weight, multiply, combine, round and shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s1_di    <= '0;
      s1_dq    <= '0;
      s1_wi    <= '0;
      s1_wq    <= '0;
      p_ii     <= '0;
      p_qq     <= '0;
      p_iq     <= '0;
      p_qi     <= '0;
      sum_i    <= '0;
      sum_q    <= '0;
      rnd_i    <= '0;
      rnd_q    <= '0;
    end else begin
      s1_valid <= din_valid;
      s1_di    <= dinI;
      s1_dq    <= dinQ;
      s1_wi    <= active_i;
      s1_wq    <= active_q;

      s2_valid <= s1_valid;
      p_ii     <= PW'(s1_di) * PW'(s1_wi);
      p_qq     <= PW'(s1_dq) * PW'(s1_wq);
      p_iq     <= PW'(s1_di) * PW'(s1_wq);
      p_qi     <= PW'(s1_dq) * PW'(s1_wi);

      s3_valid <= s2_valid;
`ifdef CONJ_WEIGHT_EN
      sum_i    <= SW'(p_ii) + SW'(p_qq);
      sum_q    <= SW'(p_qi) - SW'(p_iq);
`else
      sum_i    <= SW'(p_ii) - SW'(p_qq);
      sum_q    <= SW'(p_iq) + SW'(p_qi);
`endif

      s4_valid <= s3_valid;
      rnd_i    <= (sum_i + RND_HALF) >>> FRAC;
      rnd_q    <= (sum_q + RND_HALF) >>> FRAC;
    end
  end

  // Clip when the bits above the output sign are not a pure sign extension.
  always_comb begin
    clip_i = !((&rnd_i[SW-1:DW-1]) || !(|rnd_i[SW-1:DW-1]));
    clip_q = !((&rnd_q[SW-1:DW-1]) || !(|rnd_q[SW-1:DW-1]));
    sat_i  = rnd_i[DW-1:0];
    sat_q  = rnd_q[DW-1:0];
    if (clip_i) sat_i = rnd_i[SW-1] ? OUT_MIN : OUT_MAX;
    if (clip_q) sat_q = rnd_q[SW-1] ? OUT_MIN : OUT_MAX;
  end

  // Output register: data holds through bubbles, flag only rides with valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      doutI      <= '0;
      doutQ      <= '0;
      sat_flag   <= 1'b0;
    end else begin
      dout_valid <= s4_valid;
      sat_flag   <= s4_valid && (clip_i || clip_q);
      if (s4_valid) begin
        doutI <= sat_i;
        doutQ <= sat_q;
      end
    end
  end

endmodule

// File: tb/tb_beam_weight_cmul.sv
// Directed bench for beam_weight_cmul (default build, plain complex product).
module tb_beam_weight_cmul;

  logic               clk = 1'b0;
  logic               rst;
  logic               din_valid;
  logic signed [17:0] dinI, dinQ;
  logic               w_load;
  logic signed [17:0] wI, wQ;
  logic               w_commit;
  logic               w_pending;
  logic               dout_valid;
  logic signed [17:0] doutI, doutQ;
  logic               sat_flag;

  int checks   = 0;
  int failures = 0;

  beam_weight_cmul dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .dinI       (dinI),
    .dinQ       (dinQ),
    .w_load     (w_load),
    .wI         (wI),
    .wQ         (wQ),
    .w_commit   (w_commit),
    .w_pending  (w_pending),
    .dout_valid (dout_valid),
    .doutI      (doutI),
    .doutQ      (doutQ),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  // All drivers change inputs 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weight(input logic signed [17:0] wi, input logic signed [17:0] wq);
    wI = wi; wQ = wq; w_load = 1'b1;
    step();
    w_load = 1'b0;
  endtask

  task automatic commit_weight();
    w_commit = 1'b1;
    step();
    w_commit = 1'b0;
  endtask

  // One isolated sample; returns what the output register shows at N+4.
  task automatic run_sample(input logic signed [17:0] di, input logic signed [17:0] dq,
                            output logic ov, output logic signed [17:0] oi,
                            output logic signed [17:0] oq, output logic os);
    dinI = di; dinQ = dq; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    step();
    ov = dout_valid; oi = doutI; oq = doutQ; os = sat_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || doutI !== 18'sd0 || doutQ !== 18'sd0 || sat_flag !== 1'b0 || w_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%0b I=%0d Q=%0d sat=%0b pend=%0b, want all 0",
               dout_valid, doutI, doutQ, sat_flag, w_pending);
    end
  endtask

  task automatic test_default_weight();
    dinI = 18'sd1000; dinQ = -18'sd2000; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (2) step();
    step();
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: dout_valid=%0b at N+3, want 0", dout_valid);
    end
    step();
    checks++;
    if (dout_valid !== 1'b1 || doutI !== 18'sd1000 || doutQ !== -18'sd2000 || sat_flag !== 1'b0 || w_pending !== 1'b0) begin
      failures++;
      $display("FAIL default_weight: got v=%0b (%0d,%0d) sat=%0b pend=%0b, want v=1 (1000,-2000) sat=0 pend=0",
               dout_valid, doutI, doutQ, sat_flag, w_pending);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0 || doutI !== 18'sd1000 || doutQ !== -18'sd2000 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL bubble_hold: got v=%0b (%0d,%0d) sat=%0b, want v=0 (1000,-2000) sat=0",
               dout_valid, doutI, doutQ, sat_flag);
    end
  endtask

  task automatic test_half_j_weight();
    logic ov, os;
    logic signed [17:0] oi, oq;
    load_weight(18'sd0, 18'sd65536);
    checks++;
    if (w_pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_after_load: got %0b want 1", w_pending);
    end
    commit_weight();
    checks++;
    if (w_pending !== 1'b0) begin
      failures++;
      $display("FAIL pending_after_commit: got %0b want 0", w_pending);
    end
    run_sample(18'sd4000, 18'sd2000, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== -18'sd1000 || oq !== 18'sd2000 || os !== 1'b0) begin
      failures++;
      $display("FAIL half_j: got v=%0b (%0d,%0d) sat=%0b, want v=1 (-1000,2000) sat=0", ov, oi, oq, os);
    end
  endtask

  task automatic test_rounding();
    logic ov, os;
    logic signed [17:0] oi, oq;
    load_weight(18'sd65536, 18'sd0);
    commit_weight();
    run_sample(18'sd1, 18'sd0, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd1 || oq !== 18'sd0) begin
      failures++;
      $display("FAIL round_pos_half: got v=%0b (%0d,%0d), want v=1 (1,0)", ov, oi, oq);
    end
    run_sample(-18'sd1, 18'sd0, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd0 || oq !== 18'sd0) begin
      failures++;
      $display("FAIL round_neg_half: got v=%0b (%0d,%0d), want v=1 (0,0)", ov, oi, oq);
    end
    run_sample(18'sd3, -18'sd3, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd2 || oq !== -18'sd1) begin
      failures++;
      $display("FAIL round_1p5: got v=%0b (%0d,%0d), want v=1 (2,-1)", ov, oi, oq);
    end
  endtask

  task automatic test_saturation();
    logic ov, os;
    logic signed [17:0] oi, oq;
    load_weight(-18'sd131072, 18'sd0);
    commit_weight();
    run_sample(-18'sd131072, -18'sd131072, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd131071 || oq !== 18'sd131071 || os !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos: got v=%0b (%0d,%0d) sat=%0b, want v=1 (131071,131071) sat=1", ov, oi, oq, os);
    end
    load_weight(-18'sd131072, 18'sd131071);
    commit_weight();
    run_sample(18'sd131071, 18'sd131071, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== -18'sd131072 || oq !== -18'sd1 || os !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: got v=%0b (%0d,%0d) sat=%0b, want v=1 (-131072,-1) sat=1", ov, oi, oq, os);
    end
    step();
    checks++;
    if (dout_valid !== 1'b0 || sat_flag !== 1'b0 || doutI !== -18'sd131072 || doutQ !== -18'sd1) begin
      failures++;
      $display("FAIL sat_bubble: got v=%0b (%0d,%0d) sat=%0b, want v=0 (-131072,-1) sat=0",
               dout_valid, doutI, doutQ, sat_flag);
    end
  endtask

  task automatic test_commit_boundary();
    logic signed [17:0] ei, eq;
    load_weight(18'sd131071, 18'sd0);
    commit_weight();
    load_weight(18'sd0, 18'sd131071);
    dinI = 18'sd8192; dinQ = 18'sd0;
    for (int k = 0; k < 12; k++) begin
      din_valid = (k < 8);
      w_commit  = (k == 4);
      step();
      w_commit = 1'b0;
      if (k >= 4) begin
        ei = (k - 4 <= 4) ? 18'sd8192 : 18'sd0;
        eq = (k - 4 <= 4) ? 18'sd0 : 18'sd8192;
        checks++;
        if (dout_valid !== 1'b1 || doutI !== ei || doutQ !== eq) begin
          failures++;
          $display("FAIL commit_boundary[%0d]: got v=%0b (%0d,%0d), want v=1 (%0d,%0d)",
                   k - 4, dout_valid, doutI, doutQ, ei, eq);
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_load_and_commit();
    logic ov, os;
    logic signed [17:0] oi, oq;
    load_weight(18'sd65536, 18'sd0);
    wI = 18'sd0; wQ = 18'sd65536; w_load = 1'b1; w_commit = 1'b1;
    step();
    w_load = 1'b0; w_commit = 1'b0;
    checks++;
    if (w_pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_load_commit: got %0b want 1", w_pending);
    end
    run_sample(18'sd4000, 18'sd2000, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd2000 || oq !== 18'sd1000) begin
      failures++;
      $display("FAIL old_shadow_active: got v=%0b (%0d,%0d), want v=1 (2000,1000)", ov, oi, oq);
    end
    commit_weight();
    checks++;
    if (w_pending !== 1'b0) begin
      failures++;
      $display("FAIL pending_lone_commit: got %0b want 0", w_pending);
    end
    run_sample(18'sd4000, 18'sd2000, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== -18'sd1000 || oq !== 18'sd2000) begin
      failures++;
      $display("FAIL new_shadow_active: got v=%0b (%0d,%0d), want v=1 (-1000,2000)", ov, oi, oq);
    end
  endtask

  task automatic test_reset_in_flight();
    logic ov, os;
    logic signed [17:0] oi, oq;
    dinI = 18'sd1000; dinQ = -18'sd2000;
    wI = 18'sd0; wQ = 18'sd131071;
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1;
      w_load    = (k == 1);
      step();
    end
    din_valid = 1'b0; w_load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (w_pending !== 1'b0) begin
      failures++;
      $display("FAIL pending_after_rst: got %0b want 0", w_pending);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_valid !== 1'b0 || doutI !== 18'sd0 || doutQ !== 18'sd0 || sat_flag !== 1'b0) begin
        failures++;
        $display("FAIL flush[%0d]: got v=%0b (%0d,%0d) sat=%0b, want v=0 (0,0) sat=0",
                 k, dout_valid, doutI, doutQ, sat_flag);
      end
      step();
    end
    commit_weight();
    run_sample(18'sd1000, -18'sd2000, ov, oi, oq, os);
    checks++;
    if (ov !== 1'b1 || oi !== 18'sd1000 || oq !== -18'sd2000 || os !== 1'b0) begin
      failures++;
      $display("FAIL weight_after_rst: got v=%0b (%0d,%0d) sat=%0b, want v=1 (1000,-2000) sat=0", ov, oi, oq, os);
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; dinI = '0; dinQ = '0;
    w_load = 1'b0; w_commit = 1'b0; wI = '0; wQ = '0;
    #1;
    test_reset();
    test_default_weight();
    test_half_j_weight();
    test_rounding();
    test_saturation();
    test_commit_boundary();
    test_load_and_commit();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
